// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer (tx_clk domain).
// Takes one frame per packet as a valid/ready/last byte stream starting at the
// destination MAC. Adds preamble/SFD and inline FCS, and enforces the inter-frame gap.
// Aborts on source underflow or oversize frames, and keeps sent/aborted counters.
// Optional feature: define ETH_TX_PAD_EN to pad frames shorter than MIN_FRAME with 0x00.
module eth_tx_framer #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_CYCLES   = 12,
  parameter int unsigned MIN_FRAME    = 60,
  parameter int unsigned MAX_FRAME    = 1514
) (
  input  logic        tx_clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_er,
  output logic        busy,
  output logic [31:0] frame_cnt,
  output logic [15:0] abort_cnt
);

  // The byte counter must hold whichever frame limit is larger.
  localparam int unsigned CNT_LIMIT = (MIN_FRAME > MAX_FRAME) ? MIN_FRAME : MAX_FRAME;
  localparam int unsigned CNT_W     = $clog2(CNT_LIMIT + 1);
  localparam int unsigned AUX_W     = 16;
  // The IDLE cycle before the next preamble is part of the gap, so IFG is one short.
  localparam int unsigned IFG_LAST  = (IFG_CYCLES > 1) ? IFG_CYCLES - 2 : 0;

  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    DATA     = 3'd2,
`ifdef ETH_TX_PAD_EN
    PAD      = 3'd3,
`endif
    FCS      = 3'd4,
    IFG      = 3'd5,
    DRAIN    = 3'd6
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   byte_cnt, byte_cnt_next;
  logic [AUX_W-1:0]   aux_cnt, aux_cnt_next;
  logic [31:0]        crc, crc_next;
  logic [7:0]         tx_data_next;
  logic               tx_valid_next;
  logic               tx_er_next;
  logic               frame_inc;
  logic               abort_inc;

  // One byte of reflected CRC-32 update.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Next-state, next-output and counter-update decode.
  always_comb begin
    state_next    = state;
    byte_cnt_next = byte_cnt;
    aux_cnt_next  = aux_cnt;
    crc_next      = crc;
    tx_data_next  = 8'h00;
    tx_valid_next = 1'b0;
    tx_er_next    = 1'b0;
    frame_inc     = 1'b0;
    abort_inc     = 1'b0;

    case (state)
      IDLE: begin
        byte_cnt_next = '0;
        aux_cnt_next  = '0;
        crc_next      = CRC_INIT;
        if (s_valid) state_next = PREAMBLE;
      end

      PREAMBLE: begin
        tx_valid_next = 1'b1;
        if (aux_cnt == AUX_W'(PREAMBLE_LEN)) begin
          tx_data_next = SFD_BYTE;
          aux_cnt_next = '0;
          state_next   = DATA;
        end else begin
          tx_data_next = PRE_BYTE;
          aux_cnt_next = aux_cnt + AUX_W'(1);
        end
      end

      DATA: begin
        aux_cnt_next = '0;
        if (!s_valid) begin
          // Source underflow: single abort cycle, then discard the rest.
          tx_valid_next = 1'b1;
          tx_er_next    = 1'b1;
          abort_inc     = 1'b1;
          state_next    = DRAIN;
        end else if (byte_cnt == CNT_W'(MAX_FRAME)) begin
          // Oversize: this byte is swallowed and replaced by the abort cycle.
          tx_valid_next = 1'b1;
          tx_er_next    = 1'b1;
          abort_inc     = 1'b1;
          state_next    = s_last ? IFG : DRAIN;
        end else begin
          tx_valid_next = 1'b1;
          tx_data_next  = s_data;
          crc_next      = crc_byte(crc, s_data);
          byte_cnt_next = byte_cnt + CNT_W'(1);
          if (s_last) begin
`ifdef ETH_TX_PAD_EN
            if ((byte_cnt + CNT_W'(1)) < CNT_W'(MIN_FRAME)) state_next = PAD;
            else                                          state_next = FCS;
`else
            state_next = FCS;
`endif
          end
        end
      end

`ifdef ETH_TX_PAD_EN
      PAD: begin
        aux_cnt_next  = '0;
        tx_valid_next = 1'b1;
        tx_data_next  = 8'h00;
        crc_next      = crc_byte(crc, 8'h00);
        byte_cnt_next = byte_cnt + CNT_W'(1);
        if ((byte_cnt + CNT_W'(1)) == CNT_W'(MIN_FRAME)) state_next = FCS;
      end
`endif

      FCS: begin
        tx_valid_next = 1'b1;
        case (aux_cnt[1:0])
          2'd0:    tx_data_next = ~crc[7:0];
          2'd1:    tx_data_next = ~crc[15:8];
          2'd2:    tx_data_next = ~crc[23:16];
          default: tx_data_next = ~crc[31:24];
        endcase
        if (aux_cnt[1:0] == 2'd3) begin
          frame_inc    = 1'b1;
          aux_cnt_next = '0;
          state_next   = IFG;
        end else begin
          aux_cnt_next = aux_cnt + AUX_W'(1);
        end
      end

      IFG: begin
        if (aux_cnt == AUX_W'(IFG_LAST)) begin
          aux_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          aux_cnt_next = aux_cnt + AUX_W'(1);
        end
      end

      DRAIN: begin
        aux_cnt_next = '0;
        if (s_valid && s_last) state_next = IFG;
      end

      default: state_next = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      aux_cnt   <= '0;
      crc       <= CRC_INIT;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      tx_er     <= 1'b0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= 32'd0;
      abort_cnt <= 16'd0;
    end else begin
      state    <= state_next;
      byte_cnt <= byte_cnt_next;
      aux_cnt  <= aux_cnt_next;
      crc      <= crc_next;
      tx_data  <= tx_data_next;
      tx_valid <= tx_valid_next;
      tx_er    <= tx_er_next;
      s_ready  <= (state_next == DATA) || (state_next == DRAIN);
      busy     <= (state != IDLE) && (state_next != IDLE);
      if (frame_inc) frame_cnt <= frame_cnt + 32'd1;
      if (abort_inc && (abort_cnt != 16'hFFFF)) abort_cnt <= abort_cnt + 16'd1;
    end
  end

endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Parametrised Ethernet transmit framer in the tx_clk (125 MHz) domain, between the header/payload generators and the RGMII transmit stage. Accepts one frame per packet as a byte stream with valid/ready/last, starting at destination MAC. Prepends preamble/SFD, pads short frames, computes and appends FCS inline, enforces inter-frame gap. Aborts cleanly on source underflow or oversize frames, and keeps sent/aborted counters.

## Interface
- PREAMBLE_LEN, 7: count of 0x55 bytes before SFD (0xD5).
- IFG_CYCLES, 12: idle cycles (tx_valid=0) after a frame or abort.
- MIN_FRAME, 60: minimum bytes before FCS; padding target.
- MAX_FRAME, 1514: maximum accepted bytes before FCS.
- tx_clk  in  1  byte clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_data  in  8  frame byte from source.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final frame byte; qualified by s_valid.
- s_ready  out  1  framer accepts a byte this cycle.
- tx_data  out  8  byte to RGMII stage.
- tx_valid  out  1  tx_data valid (maps to TX_EN).
- tx_er  out  1  error/abort marker (maps to TX_ER).
- busy  out  1  high from the first preamble byte through the end of IFG.
- frame_cnt  out  32  frames completed; wraps.
- abort_cnt  out  16  frames aborted; saturates at 0xFFFF.

## Operation
- States: IDLE, PREAMBLE, DATA, PAD, FCS, IFG, DRAIN.
- IDLE: s_ready=0. s_valid=1 starts PREAMBLE on the next edge. The s_data byte is not consumed.
- PREAMBLE: emits PREAMBLE_LEN × 0x55, then 0xD5. The SFD cycle enters DATA.
- DATA: s_ready=1. Each accepted byte goes to tx_data and through CRC. The byte counter (11 bits) increments.
  - Accept with s_last=1: go to PAD if count<MIN_FRAME, else FCS.
  - s_valid=0 in DATA is underflow. Emit one abort cycle: tx_valid=1, tx_er=1, tx_data=0x00. Then go to DRAIN.
  - Accepting byte number MAX_FRAME+1: that byte is not sent. Emit the abort cycle. If that byte carried s_last, go to IFG; otherwise go to DRAIN.
- PAD: emits 0x00 bytes, each included in the CRC, until count==MIN_FRAME. Then FCS.
- FCS: CRC-32 with reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final complement. Four bytes, LSB first. The 4th byte increments frame_cnt, then IFG.
- DRAIN: s_ready=1, tx_valid=0, bytes discarded until s_valid&s_last. Then IFG. Entering DRAIN or the direct abort→IFG path increments abort_cnt once.
- IFG: counts IFG_CYCLES with s_ready=0, then IDLE.

## Timing
- Outputs are registered. s_ready is decoded from state.
- s_valid high in IDLE at edge 0 → first 0x55 at edge 1. SFD at edge PREAMBLE_LEN+1.
- The first frame byte appears on tx_data in the cycle immediately after SFD. tx_valid has no gaps from preamble through the last FCS byte.
- Byte accepted at edge N is on tx_data after edge N. FCS bytes immediately follow the last data or pad byte.
- Next preamble starts no earlier than IFG_CYCLES+1 edges after the last FCS or abort cycle.
- Reset (asynchronous, any state) forces:
  - state IDLE;
  - tx_data=0x00, tx_valid=0, tx_er=0, s_ready=0, busy=0;
  - counters 0, CRC 0xFFFFFFFF.
  - No IFG after reset. A mid-frame reset truncates the frame with no tx_er.
- tx_er is only ever high for the single abort cycle.

## Configuration
- ETH_TX_PAD_EN defined: PAD state present; frames shorter than MIN_FRAME are padded with 0x00.
- ETH_TX_PAD_EN undefined: PAD state and MIN_FRAME logic removed. s_last goes straight to FCS, and short frames are sent unpadded.

## Test plan
- Padding off, 9 bytes "123456789" with s_last on '9':
  - tx_data = 7×0x55, 0xD5, 0x31..0x39, then 0x26 0x39 0xF4 0xCB.
  - tx_valid high for 21 contiguous cycles; frame_cnt=1.
- Padding on, 14-byte frame: 46×0x00 pad bytes, then FCS. tx_valid high for 8+60+4=72 cycles.
- Back-to-back frames with s_valid held high: exactly 12 cycles with tx_valid=0 between the last FCS byte and the next 0x55. s_ready=0 throughout the gap.
- s_valid dropped after byte 20 of a 64-byte frame:
  - one cycle with tx_valid=1, tx_er=1, tx_data=0x00;
  - the remaining 44 bytes are drained without tx_valid;
  - abort_cnt=1, frame_cnt unchanged.
- 1600-byte frame: 1514 bytes transmitted, then the abort cycle. The remaining bytes are drained; abort_cnt increments.
- rst pulsed during FCS byte 2: all outputs are 0 immediately, counters cleared. The next frame starts its preamble 1 edge after s_valid, with no IFG wait.
